// File: rtl/pcpi_issue_ctrl_if.sv
// ----------------------------------------------------------------------------
// pcpi_issue_ctrl_if
// Bundles the three handshakes around the PCPI issue controller:
//   req_*  : upstream request (valid/ready + insn/rs1/rs2)
//   rsp_*  : downstream response (valid/ready + wr/rd/timeout/latency)
//   pcpi_* : PCPI request side toward a coprocessor and its reply
// Modports:
//   master : the issue controller's view (drives req_ready, rsp_*, pcpi request)
//   slave  : the environment's view (requester, response sink and coprocessor)
// ----------------------------------------------------------------------------
interface pcpi_issue_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_insn;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;

    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_wr;
    logic [31:0] rsp_rd;
    logic        rsp_timeout;
    logic [15:0] rsp_latency;

    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic [31:0] pcpi_rs1;
    logic [31:0] pcpi_rs2;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;
    logic        pcpi_wait;
    logic        pcpi_ready;

    modport master (
        input  req_valid, req_insn, req_rs1, req_rs2,
        output req_ready,
        input  rsp_ready,
        output rsp_valid, rsp_wr, rsp_rd, rsp_timeout, rsp_latency,
        output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
        input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
    );

    modport slave (
        output req_valid, req_insn, req_rs1, req_rs2,
        input  req_ready,
        output rsp_ready,
        input  rsp_valid, rsp_wr, rsp_rd, rsp_timeout, rsp_latency,
        input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
        output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
    );
endinterface

// File: rtl/pcpi_issue_ctrl.sv
// ----------------------------------------------------------------------------
// pcpi_issue_ctrl
// PCPI initiator: accepts one instruction at a time, presents it to a PCPI
// coprocessor, waits for pcpi_ready and returns result, write flag and issue
// latency. An instruction that is never claimed (no pcpi_wait, no pcpi_ready)
// is aborted after TIMEOUT_CYCLES consecutive idle issue cycles.
// Ports:
//   i_clk    : clock, all state updates on the rising edge
//   i_reset  : synchronous active-high reset
//   io_bus   : pcpi_issue_ctrl_if.master (req / rsp / pcpi handshakes)
// Parameters:
//   TIMEOUT_CYCLES : idle issue cycles before abort, legal range 2..65535
// ----------------------------------------------------------------------------
module pcpi_issue_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    pcpi_issue_ctrl_if.master      io_bus
);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    localparam logic [15:0] IdleLast = 16'(TIMEOUT_CYCLES - 1);

    state_e      r_state,       w_state_next;
    logic        r_pcpi_valid,  w_pcpi_valid_next;
    logic [31:0] r_pcpi_insn,   w_pcpi_insn_next;
    logic [31:0] r_pcpi_rs1,    w_pcpi_rs1_next;
    logic [31:0] r_pcpi_rs2,    w_pcpi_rs2_next;
    logic        r_rsp_wr,      w_rsp_wr_next;
    logic [31:0] r_rsp_rd,      w_rsp_rd_next;
    logic        r_rsp_timeout, w_rsp_timeout_next;
    logic [15:0] r_rsp_latency, w_rsp_latency_next;
    logic [15:0] r_idle_cnt,    w_idle_cnt_next;
    logic [15:0] r_lat_cnt,     w_lat_cnt_next;
    logic [15:0] w_lat_inc;

    // Latency including the current issue cycle, saturating at 0xFFFF.
    assign w_lat_inc = (r_lat_cnt == 16'hFFFF) ? r_lat_cnt : r_lat_cnt + 16'd1;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= StIdle;
            r_pcpi_valid  <= 1'b0;
            r_pcpi_insn   <= '0;
            r_pcpi_rs1    <= '0;
            r_pcpi_rs2    <= '0;
            r_rsp_wr      <= 1'b0;
            r_rsp_rd      <= '0;
            r_rsp_timeout <= 1'b0;
            r_rsp_latency <= '0;
            r_idle_cnt    <= '0;
            r_lat_cnt     <= '0;
        end else begin
            r_state       <= w_state_next;
            r_pcpi_valid  <= w_pcpi_valid_next;
            r_pcpi_insn   <= w_pcpi_insn_next;
            r_pcpi_rs1    <= w_pcpi_rs1_next;
            r_pcpi_rs2    <= w_pcpi_rs2_next;
            r_rsp_wr      <= w_rsp_wr_next;
            r_rsp_rd      <= w_rsp_rd_next;
            r_rsp_timeout <= w_rsp_timeout_next;
            r_rsp_latency <= w_rsp_latency_next;
            r_idle_cnt    <= w_idle_cnt_next;
            r_lat_cnt     <= w_lat_cnt_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_pcpi_valid_next  = r_pcpi_valid;
        w_pcpi_insn_next   = r_pcpi_insn;
        w_pcpi_rs1_next    = r_pcpi_rs1;
        w_pcpi_rs2_next    = r_pcpi_rs2;
        w_rsp_wr_next      = r_rsp_wr;
        w_rsp_rd_next      = r_rsp_rd;
        w_rsp_timeout_next = r_rsp_timeout;
        w_rsp_latency_next = r_rsp_latency;
        w_idle_cnt_next    = r_idle_cnt;
        w_lat_cnt_next     = r_lat_cnt;

        case (r_state)
            StIdle: begin
                if (io_bus.req_valid) begin
                    w_state_next      = StIssue;
                    w_pcpi_valid_next = 1'b1;
                    w_pcpi_insn_next  = io_bus.req_insn;
                    w_pcpi_rs1_next   = io_bus.req_rs1;
                    w_pcpi_rs2_next   = io_bus.req_rs2;
                    w_idle_cnt_next   = '0;
                    w_lat_cnt_next    = '0;
                end
            end
            StIssue: begin
                w_lat_cnt_next = w_lat_inc;
                // pcpi_ready wins over a timeout landing in the same cycle.
                if (io_bus.pcpi_ready) begin
                    w_state_next       = StResp;
                    w_pcpi_valid_next  = 1'b0;
                    w_rsp_wr_next      = io_bus.pcpi_wr;
                    w_rsp_rd_next      = io_bus.pcpi_wr ? io_bus.pcpi_rd : 32'd0;
                    w_rsp_timeout_next = 1'b0;
                    w_rsp_latency_next = w_lat_inc;
                end else if (io_bus.pcpi_wait) begin
                    w_idle_cnt_next = '0;
                end else if (r_idle_cnt == IdleLast) begin
                    w_state_next       = StResp;
                    w_pcpi_valid_next  = 1'b0;
                    w_rsp_wr_next      = 1'b0;
                    w_rsp_rd_next      = '0;
                    w_rsp_timeout_next = 1'b1;
                    w_rsp_latency_next = w_lat_inc;
                end else begin
                    w_idle_cnt_next = r_idle_cnt + 16'd1;
                end
            end
            StResp: begin
                // Response data holds until consumed; no accept in this cycle.
                if (io_bus.rsp_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    assign io_bus.req_ready   = (r_state == StIdle);
    assign io_bus.rsp_valid   = (r_state == StResp);
    assign io_bus.rsp_wr      = r_rsp_wr;
    assign io_bus.rsp_rd      = r_rsp_rd;
    assign io_bus.rsp_timeout = r_rsp_timeout;
    assign io_bus.rsp_latency = r_rsp_latency;
    assign io_bus.pcpi_valid  = r_pcpi_valid;
    assign io_bus.pcpi_insn   = r_pcpi_insn;
    assign io_bus.pcpi_rs1    = r_pcpi_rs1;
    assign io_bus.pcpi_rs2    = r_pcpi_rs2;

endmodule

// File: tb/tb_pcpi_issue_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pcpi_issue_ctrl
// Directed bench for pcpi_issue_ctrl. A behavioural coprocessor stub answers
// in one of several modes: silent, 5-cycle multiplier, long wait with a fixed
// result on cycle 41, and a stray always-ready responder.
// ----------------------------------------------------------------------------
module tb_pcpi_issue_ctrl;

    localparam int MulLat = 5;
    localparam logic [31:0] InsnMul    = 32'h0200_0033;
    localparam logic [31:0] InsnMulh   = 32'h0200_1033;
    localparam logic [31:0] InsnMulhsu = 32'h0200_2033;
    localparam logic [31:0] InsnMulhu  = 32'h0200_3033;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   mode;
    int   vcount;
    logic [15:0] stub_cnt;

    pcpi_issue_ctrl_if bus ();

    pcpi_issue_ctrl #(
        .TIMEOUT_CYCLES (16)
    ) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .io_bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier reference: MUL / MULH / MULHSU / MULHU selected by funct3.
    function automatic logic [31:0] mul_model(input logic [31:0] insn,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [64:0] ea;
        logic signed [64:0] eb;
        logic signed [64:0] p;
        logic [2:0]         f3;
        f3 = insn[14:12];
        ea = (f3 == 3'd1 || f3 == 3'd2) ? {{33{a[31]}}, a} : {33'd0, a};
        eb = (f3 == 3'd1) ? {{33{b[31]}}, b} : {33'd0, b};
        p  = ea * eb;
        return (f3 == 3'd0) ? p[31:0] : p[63:32];
    endfunction

    // Cycle index of the current valid cycle is stub_cnt + 1.
    always @(posedge clk) begin
        if (!bus.pcpi_valid || bus.pcpi_ready) stub_cnt <= '0;
        else                                   stub_cnt <= stub_cnt + 16'd1;
    end

    always_comb begin
        bus.pcpi_ready = 1'b0;
        bus.pcpi_wait  = 1'b0;
        bus.pcpi_wr    = 1'b0;
        bus.pcpi_rd    = 32'd0;
        case (mode)
            1: if (bus.pcpi_valid) begin
                if (32'(stub_cnt) + 1 == MulLat) begin
                    bus.pcpi_ready = 1'b1;
                    bus.pcpi_wr    = 1'b1;
                    bus.pcpi_rd    = mul_model(bus.pcpi_insn, bus.pcpi_rs1, bus.pcpi_rs2);
                end else begin
                    bus.pcpi_wait = 1'b1;
                end
            end
            2: if (bus.pcpi_valid) begin
                if (32'(stub_cnt) + 1 == 41) begin
                    bus.pcpi_ready = 1'b1;
                    bus.pcpi_wr    = 1'b1;
                    bus.pcpi_rd    = 32'hDEAD_BEEF;
                end else begin
                    bus.pcpi_wait = 1'b1;
                end
            end
            3: begin
                bus.pcpi_ready = 1'b1;
                bus.pcpi_wait  = 1'b1;
                bus.pcpi_wr    = 1'b1;
                bus.pcpi_rd    = 32'h1234_5678;
            end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b);
        bus.req_valid = 1'b1;
        bus.req_insn  = insn;
        bus.req_rs1   = a;
        bus.req_rs2   = b;
        tick();
        bus.req_valid = 1'b0;
    endtask

    // Counts valid cycles until rsp_valid; an expired budget is a failed check.
    task automatic wait_rsp(input int budget, output int cnt);
        cnt = 0;
        for (int i = 0; i < budget; i++) begin
            if (bus.rsp_valid) break;
            if (bus.pcpi_valid) cnt++;
            tick();
        end
        chk("rsp_arrived", 64'(bus.rsp_valid), 64'd1);
    endtask

    task automatic consume();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        mode          = 0;
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_insn  = '0;
        bus.req_rs1   = '0;
        bus.req_rs2   = '0;
        bus.rsp_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_req_ready",   64'(bus.req_ready),   64'd1);
        chk("rst_rsp_valid",   64'(bus.rsp_valid),   64'd0);
        chk("rst_pcpi_valid",  64'(bus.pcpi_valid),  64'd0);
        chk("rst_pcpi_insn",   64'(bus.pcpi_insn),   64'd0);
        chk("rst_rsp_rd",      64'(bus.rsp_rd),      64'd0);
        chk("rst_rsp_wr",      64'(bus.rsp_wr),      64'd0);
        chk("rst_rsp_timeout", 64'(bus.rsp_timeout), 64'd0);
        chk("rst_rsp_latency", 64'(bus.rsp_latency), 64'd0);

        // Stray pcpi_ready in IDLE must not change anything
        mode = 3;
        tick();
        tick();
        tick();
        chk("stray_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("stray_rsp_rd",    64'(bus.rsp_rd),    64'd0);
        chk("stray_rsp_wr",    64'(bus.rsp_wr),    64'd0);
        chk("stray_req_ready", 64'(bus.req_ready), 64'd1);
        mode = 1;

        // MUL 3*7
        issue(InsnMul, 32'd3, 32'd7);
        chk("mul_pcpi_valid", 64'(bus.pcpi_valid), 64'd1);
        chk("mul_pcpi_insn",  64'(bus.pcpi_insn),  64'h0200_0033);
        chk("mul_req_ready",  64'(bus.req_ready),  64'd0);
        wait_rsp(50, vcount);
        chk("mul_rd",         64'(bus.rsp_rd),      64'd21);
        chk("mul_wr",         64'(bus.rsp_wr),      64'd1);
        chk("mul_timeout",    64'(bus.rsp_timeout), 64'd0);
        chk("mul_latency",    64'(bus.rsp_latency), 64'd5);
        chk("mul_vcycles",    64'(vcount),          64'd5);
        chk("mul_valid_drop", 64'(bus.pcpi_valid),  64'd0);
        consume();
        chk("mul_back_idle",  64'(bus.req_ready),   64'd1);

        issue(InsnMulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_rsp(50, vcount);
        chk("mulhu_rd", 64'(bus.rsp_rd), 64'hFFFF_FFFE);
        consume();

        issue(InsnMulh, -32'sd10, -32'sd4);
        wait_rsp(50, vcount);
        chk("mulh_rd", 64'(bus.rsp_rd), 64'h0);
        consume();

        issue(InsnMulhsu, -32'sd10, 32'd4);
        wait_rsp(50, vcount);
        chk("mulhsu_rd", 64'(bus.rsp_rd), 64'hFFFF_FFFF);
        consume();

        // Unclaimed instruction times out after 16 valid cycles
        mode = 0;
        issue(InsnMul, 32'd1, 32'd2);
        wait_rsp(100, vcount);
        chk("to_timeout", 64'(bus.rsp_timeout), 64'd1);
        chk("to_wr",      64'(bus.rsp_wr),      64'd0);
        chk("to_rd",      64'(bus.rsp_rd),      64'd0);
        chk("to_latency", 64'(bus.rsp_latency), 64'd16);
        chk("to_vcycles", 64'(vcount),          64'd16);
        consume();

        // Long pcpi_wait, result on cycle 41
        mode = 2;
        issue(InsnMul, 32'd9, 32'd9);
        wait_rsp(100, vcount);
        chk("wait_timeout", 64'(bus.rsp_timeout), 64'd0);
        chk("wait_rd",      64'(bus.rsp_rd),      64'hDEAD_BEEF);
        chk("wait_wr",      64'(bus.rsp_wr),      64'd1);
        chk("wait_latency", 64'(bus.rsp_latency), 64'd41);

        // Back-pressure: response held, next request waits
        mode          = 1;
        bus.req_valid = 1'b1;
        bus.req_insn  = InsnMul;
        bus.req_rs1   = 32'd2;
        bus.req_rs2   = 32'd5;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_rsp_valid", 64'(bus.rsp_valid),   64'd1);
            chk("hold_req_ready", 64'(bus.req_ready),   64'd0);
            chk("hold_rd",        64'(bus.rsp_rd),      64'hDEAD_BEEF);
            chk("hold_latency",   64'(bus.rsp_latency), 64'd41);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("rel_req_ready",  64'(bus.req_ready),  64'd1);
        chk("rel_pcpi_valid", 64'(bus.pcpi_valid), 64'd0);
        tick();
        bus.req_valid = 1'b0;
        chk("rel_accept",     64'(bus.pcpi_valid), 64'd1);
        chk("rel_rs1",        64'(bus.pcpi_rs1),   64'd2);
        wait_rsp(50, vcount);
        chk("rel_rd",         64'(bus.rsp_rd),     64'd10);
        consume();

        // Reset mid-ISSUE drops the instruction
        mode = 0;
        issue(InsnMul, 32'd4, 32'd4);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_pcpi_valid", 64'(bus.pcpi_valid), 64'd0);
        chk("mid_rst_rsp_valid",  64'(bus.rsp_valid),  64'd0);
        chk("mid_rst_req_ready",  64'(bus.req_ready),  64'd1);
        chk("mid_rst_pcpi_insn",  64'(bus.pcpi_insn),  64'd0);
        mode = 1;
        issue(InsnMul, 32'd1000, 32'd1000);
        wait_rsp(50, vcount);
        chk("post_rst_rd",      64'(bus.rsp_rd),      64'd1000000);
        chk("post_rst_latency", 64'(bus.rsp_latency), 64'd5);
        consume();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
